// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and counter-width helper for divider variants
package div_pkg;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/result handshake between a requesting master and div_seq
interface div_seq_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_zero;
  modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_zero);
  modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_zero);
endinterface

// File: rtl/div_seq_divmod.sv
// divmod: one restoring-division step on the {remainder, quotient} shift pair
module divmod #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] qo,
  output logic [WIDTH-1:0] ro
);
  logic [WIDTH:0] part;
  logic [WIDTH+1:0] diff;
  logic borrow;
  logic unused_diff;
  // shift in the next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    part = {r, q[WIDTH-1]};
    diff = {1'b0, part} - {2'b00, b};
    borrow = diff[WIDTH+1];
    ro = borrow ? part[WIDTH-1:0] : diff[WIDTH-1:0];
    qo = {q[WIDTH-2:0], ~borrow};
  end
  assign unused_diff = diff[WIDTH];
endmodule

// File: rtl/div_seq.sv
// div_seq: iterative unsigned divider, one divmod step per clock; DIV_ZERO_FAST_EN short-circuits zero divisors
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clock,
  input logic reset_n,
  div_seq_if.slave bus
);
  localparam int CW = clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] q_reg, r_reg, b_reg, qo, ro;
  logic fast;
  divmod #(.WIDTH(WIDTH)) u_stage (.q(q_reg), .b(b_reg), .r(r_reg), .qo(qo), .ro(ro));
`ifdef DIV_ZERO_FAST_EN
  assign fast = bus.divisor == '0;
`else
  assign fast = 1'b0;
`endif
  assign bus.busy = state == ST_RUN;
  assign bus.quotient = q_reg;
  assign bus.remainder = r_reg;
  // controller: accept in IDLE, iterate WIDTH times in RUN, pulse done on the last step
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      q_reg <= '0;
      r_reg <= '0;
      b_reg <= '0;
      bus.div_zero <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == ST_RUN) begin
        q_reg <= qo;
        r_reg <= ro;
        if (cnt == '0) begin
          bus.done <= 1'b1;
          state <= ST_IDLE;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else if (bus.start && fast) begin
        q_reg <= '1;
        r_reg <= bus.dividend;
        bus.div_zero <= 1'b1;
        bus.done <= 1'b1;
      end else if (bus.start) begin
        b_reg <= bus.divisor;
        q_reg <= bus.dividend;
        r_reg <= '0;
        cnt <= CW'(WIDTH - 1);
        bus.div_zero <= bus.divisor == '0;
        state <= ST_RUN;
      end
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and sweep checks of div_seq (WIDTH=32 and WIDTH=8) against a cycle-level model
module tb_div_seq;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int errors = 0;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  always #5 clock = ~clock;
  div_seq_if #(.WIDTH(32)) bus ();
  div_seq_if #(.WIDTH(8)) bus8 ();
  div_seq #(.WIDTH(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  div_seq #(.WIDTH(8)) dut8 (.clock(clock), .reset_n(reset_n), .bus(bus8));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model of the 32-bit divider: an accepted request completes WIDTH edges later
  // (or on the accepting edge for a fast zero divisor) with a/b and a%b
  bit m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  int m_left = 0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_q = '0; m_r = '0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (bus.start) begin
        p_dz = bus.divisor == 0;
        p_q = p_dz ? 32'hFFFF_FFFF : bus.dividend / bus.divisor;
        p_r = p_dz ? bus.dividend : bus.dividend % bus.divisor;
        if (FAST && p_dz) begin
          m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz;
        end else begin
          m_busy = 1; m_left = 32;
        end
      end
    end
  end

  // compare DUT against the model every cycle; results only while not busy
  always @(negedge clock) begin
    chk("cyc_busy", bus.busy, m_busy);
    chk("cyc_done", bus.done, m_done);
    if (!m_busy) begin
      chk("cyc_quotient", bus.quotient, m_q);
      chk("cyc_remainder", bus.remainder, m_r);
      chk("cyc_div_zero", bus.div_zero, m_dz);
    end
  end

  // caller sits at a negedge; returns at the negedge where done is seen
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                    input bit edz, input int elat, input int ebusy, input string tag, input int ign_at = 0);
    int lat, nb;
    lat = 0;
    nb = 0;
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1'b1;
    do begin
      @(negedge clock);
      lat++;
      if (bus.busy) nb++;
      if (ign_at != 0 && lat == ign_at) begin
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd9;
      end else bus.start = 1'b0;
    end while (!bus.done && lat < 200);
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(ebusy));
    chk({tag, "_quotient"}, bus.quotient, eq);
    chk({tag, "_remainder"}, bus.remainder, er);
    chk({tag, "_div_zero"}, bus.div_zero, edz);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic [7:0] eq, er;
    eq = (b == 0) ? 8'hFF : a / b;
    er = (b == 0) ? a : a % b;
    lat = 0;
    bus8.dividend = a;
    bus8.divisor = b;
    bus8.start = 1'b1;
    do begin
      @(negedge clock);
      lat++;
      bus8.start = 1'b0;
    end while (!bus8.done && lat < 50);
    chk("w8_latency", 64'(lat), (FAST && b == 0) ? 64'd1 : 64'd9);
    chk("w8_quotient", bus8.quotient, eq);
    chk("w8_remainder", bus8.remainder, er);
    chk("w8_div_zero", bus8.div_zero, b == 0);
  endtask

  initial begin
    bus.start = 0; bus.dividend = '0; bus.divisor = '0;
    bus8.start = 0; bus8.dividend = '0; bus8.divisor = '0;
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_div_zero", bus.div_zero, 0);
    #2 reset_n = 1'b1;
    @(negedge clock);
    op(32'd100, 32'd7, 32'd14, 32'd2, 0, 33, 32, "d100_7");
    @(negedge clock);
    op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 33, 32, "dmax_1");
    op(32'd5, 32'd9, 32'd0, 32'd5, 0, 33, 32, "b2b_5_9");
    @(negedge clock);
    op(32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1, FAST ? 1 : 33, FAST ? 0 : 32, "div0");
    @(negedge clock);
    op(32'd50, 32'd3, 32'd16, 32'd2, 0, 33, 32, "ignore", 10);
    @(negedge clock);
    bus.dividend = 32'd1000; bus.divisor = 32'd10; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (14) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      chk("abort_no_done", bus.done, 0);
    end
    op(32'd1000, 32'd10, 32'd100, 32'd0, 0, 33, 32, "after_reset");
    @(negedge clock);
    op8(8'h55, 8'd0);
    for (int a = 0; a < 256; a++) begin
      op8(8'(a), 8'd1);
      op8(8'(a), 8'd255);
      op8(8'(a), (a == 0) ? 8'd1 : 8'(a));
      op8(8'(a), 8'($urandom_range(1, 255)));
      op8(8'(a), 8'($urandom_range(1, 255)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
